// File: rtl/clause_index_table.sv
// Append-only table of clause indices: ordered pushes fill slots 0..DEPTH-1,
// and any occupied slot can be read back by position with one cycle of latency.
module clause_index_table #(
  parameter int CLAUSE_TABLE_BITS = 6,
  parameter int MAX_CLAUSES_BITS  = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         read_i,
  input  logic [CLAUSE_TABLE_BITS-1:0] index_i,
  input  logic [MAX_CLAUSES_BITS-1:0]  clause_i,
  output logic [MAX_CLAUSES_BITS-1:0]  clause_index_o,
  output logic                         full_o,
  output logic                         error_o
);

  localparam int DEPTH = 1 << CLAUSE_TABLE_BITS;
  localparam logic [CLAUSE_TABLE_BITS:0] DEPTH_CNT = (CLAUSE_TABLE_BITS+1)'(DEPTH);

  logic [MAX_CLAUSES_BITS-1:0]  mem_q [DEPTH];
  logic [CLAUSE_TABLE_BITS:0]   count_q, count_d;
  logic [MAX_CLAUSES_BITS-1:0]  rdata_q, rdata_d;
  logic                         error_q, error_d;
  logic                         full;
  logic                         push_ok;
  logic                         read_ok;

  assign full = (count_q == DEPTH_CNT);

  // Range check uses the pre-push count, so reading the slot being written is illegal.
  always_comb begin
    push_ok = push_i && !full;
    read_ok = read_i && ({1'b0, index_i} < count_q);
    count_d = count_q;
    rdata_d = rdata_q;
    error_d = (push_i && full) || (read_i && !read_ok);
    if (push_ok) begin
      count_d = count_q + 1'b1;
    end
    if (read_ok) begin
      rdata_d = mem_q[index_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Storage is left uncleared on reset; a zero count makes every slot unreachable.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[count_q[CLAUSE_TABLE_BITS-1:0]] <= clause_i;
    end
  end

  assign clause_index_o = rdata_q;
  assign full_o         = full;
  assign error_o        = error_q;

endmodule

// File: tb/tb_clause_index_table.sv
// Directed bench for clause_index_table: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_clause_index_table;

  logic       clk_i;
  logic       rst_ni;
  logic       push_i;
  logic       read_i;
  logic [5:0] index_i;
  logic [9:0] clause_i;
  logic [9:0] clause_index_o;
  logic       full_o;
  logic       error_o;

  int passed = 0;
  int total  = 0;

  clause_index_table #(
    .CLAUSE_TABLE_BITS(6),
    .MAX_CLAUSES_BITS (10)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push_i),
    .read_i        (read_i),
    .index_i       (index_i),
    .clause_i      (clause_i),
    .clause_index_o(clause_index_o),
    .full_o        (full_o),
    .error_o       (error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni   = 1'b0;
    push_i   = 1'b0;
    read_i   = 1'b0;
    index_i  = '0;
    clause_i = '0;
    tick();
    tick();
    check("reset_out",   32'(clause_index_o), 0);
    check("reset_err",   32'(error_o), 0);
    check("reset_full",  32'(full_o), 0);
    rst_ni = 1'b1;
    tick();

    // read of an empty table
    read_i  = 1'b1;
    index_i = 6'd5;
    tick();
    check("empty_rd_err",  32'(error_o), 1);
    check("empty_rd_out",  32'(clause_index_o), 0);
    check("empty_rd_full", 32'(full_o), 0);
    read_i = 1'b0;

    // push 25 values 100..124
    for (int i = 0; i < 25; i++) begin
      push_i   = 1'b1;
      clause_i = 10'(100 + i);
      tick();
      check("push25_err", 32'(error_o), 0);
    end
    push_i = 1'b0;
    tick();
    check("push25_full", 32'(full_o), 0);
    check("idle_err",    32'(error_o), 0);

    // out-of-range reads
    read_i  = 1'b1;
    index_i = 6'd30;
    tick();
    check("rd30_err", 32'(error_o), 1);
    check("rd30_out", 32'(clause_index_o), 0);
    index_i = 6'd25;
    tick();
    check("rd25_err", 32'(error_o), 1);
    check("rd25_out", 32'(clause_index_o), 0);

    // in-range reads
    index_i = 6'd24;
    tick();
    check("rd24_out", 32'(clause_index_o), 124);
    check("rd24_err", 32'(error_o), 0);
    index_i = 6'd23;
    tick();
    check("rd23_out", 32'(clause_index_o), 123);
    check("rd23_err", 32'(error_o), 0);
    read_i  = 1'b0;
    index_i = 6'd0;
    tick();
    check("hold_out", 32'(clause_index_o), 123);
    check("hold_err", 32'(error_o), 0);

    // fill to 64
    for (int i = 25; i < 64; i++) begin
      push_i   = 1'b1;
      clause_i = 10'(100 + i);
      tick();
      check("fill_err",  32'(error_o), 0);
      check("fill_full", 32'(full_o), (i == 63) ? 32'd1 : 32'd0);
    end
    clause_i = 10'd999;
    tick();
    check("ovf_err",  32'(error_o), 1);
    check("ovf_full", 32'(full_o), 1);
    push_i  = 1'b0;
    read_i  = 1'b1;
    index_i = 6'd63;
    tick();
    check("rd63_out",  32'(clause_index_o), 163);
    check("rd63_err",  32'(error_o), 0);
    check("rd63_full", 32'(full_o), 1);
    index_i = 6'd0;
    tick();
    check("rd0_out", 32'(clause_index_o), 100);
    read_i = 1'b0;

    // reset, then same-cycle push/read of slot 3
    rst_ni = 1'b0;
    #1;
    check("rst2_full", 32'(full_o), 0);
    check("rst2_out",  32'(clause_index_o), 0);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_i   = 1'b1;
      clause_i = 10'(50 + i);
      tick();
    end
    push_i  = 1'b0;
    read_i  = 1'b1;
    index_i = 6'd2;
    tick();
    check("rd2_out", 32'(clause_index_o), 52);
    push_i   = 1'b1;
    clause_i = 10'd7;
    index_i  = 6'd3;
    tick();
    check("raw_same_err", 32'(error_o), 1);
    check("raw_same_out", 32'(clause_index_o), 52);
    push_i = 1'b0;
    tick();
    check("raw_next_out", 32'(clause_index_o), 7);
    check("raw_next_err", 32'(error_o), 0);

    // illegal read then asynchronous reset mid-cycle
    index_i = 6'd10;
    tick();
    check("pre_rst_err", 32'(error_o), 1);
    read_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_out",  32'(clause_index_o), 0);
    check("async_rst_err",  32'(error_o), 0);
    check("async_rst_full", 32'(full_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
